hazard_ctrl_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_ctrl_unit.sv | 81 ++++++++
 tb/tb_hazard_ctrl_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RV32I 5-stage forwarding, stall/flush control, busy watchdog and perf counters
module hazard_ctrl_unit #(
  parameter int AW       = 5,
  parameter int CNT_W    = 32,
  parameter int BR_STAGE = 2,
  parameter int FWD_EN   = 1,
  parameter int BUSY_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_regwrite,
  input  logic             br_taken,
  input  logic             ex_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       hz_state,
  output logic             busy_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WD_W = $clog2(BUSY_MAX + 1);
  typedef enum logic [1:0] {RUN, FLUSH, STALL_RAW, STALL_BUSY} state_t;
  state_t nxt, st;
  logic [WD_W-1:0] wd_cnt;
  logic mem_a, mem_b, wb_a, wb_b, ex_w, raw1, raw2;
  // x0 never produces a hazard, so every producer match requires rd != 0
  assign mem_a = mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1;
  assign mem_b = mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2;
  assign wb_a  = wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1;
  assign wb_b  = wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2;
  assign ex_w  = ex_rd != '0 && ((FWD_EN != 0) ? ex_memread : ex_regwrite);
  always_comb begin
    raw1 = id_use1 && ((ex_w && ex_rd == id_rs1) ||
           (FWD_EN == 0 && mem_regwrite && mem_rd != '0 && mem_rd == id_rs1));
    raw2 = id_use2 && ((ex_w && ex_rd == id_rs2) ||
           (FWD_EN == 0 && mem_regwrite && mem_rd != '0 && mem_rd == id_rs2));
    nxt  = rst ? RUN : br_taken ? FLUSH : ex_busy ? STALL_BUSY : (raw1 || raw2) ? STALL_RAW : RUN;
    fwd_a = (rst || FWD_EN == 0) ? 2'b00 : mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    fwd_b = (rst || FWD_EN == 0) ? 2'b00 : mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
    pc_en       = nxt == RUN || nxt == FLUSH;
    ifid_en     = nxt == RUN || nxt == FLUSH;
    idex_en     = nxt != STALL_BUSY;
    ifid_flush  = nxt == FLUSH;
    idex_flush  = (nxt == FLUSH && BR_STAGE >= 1) || nxt == STALL_RAW;
    exmem_flush = (nxt == FLUSH && BR_STAGE == 2) || nxt == STALL_BUSY;
  end
  assign hz_state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= RUN;
      wd_cnt       <= '0;
      busy_timeout <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      st <= nxt;
      if ((nxt == STALL_RAW || nxt == STALL_BUSY) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (nxt == FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      wd_cnt <= (nxt != STALL_BUSY) ? '0 : (wd_cnt == WD_W'(BUSY_MAX)) ? wd_cnt : wd_cnt + 1'b1;
      if (nxt == STALL_BUSY && wd_cnt >= WD_W'(BUSY_MAX - 1)) busy_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench driving a forwarding and a non-forwarding instance in parallel
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, br_taken, ex_busy;
  logic [1:0] fa1, fb1, hz1, fa0, fb0, hz0;
  logic pc1, ifid1, idex1, iff1, idf1, exf1, to1;
  logic pc0, ifid0, idex0, iff0, idf0, exf0, to0;
  logic [3:0] sc1, fc1, sc0, fc0;
  logic [9:0] o1, o0;
  logic [10:0] r1, r0;
  int pass_cnt = 0;
  int total = 0;
  string nq[$];
  logic [15:0] vq[$];
  string n;
  logic [15:0] ev;
  localparam logic [9:0] RUN_O   = 10'b0000111000;
  localparam logic [9:0] RAW_O   = 10'b0000001010;
  localparam logic [9:0] BUSY_O  = 10'b0000000001;
  localparam logic [9:0] FLUSH_O = 10'b0000111111;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.AW(5), .CNT_W(4), .BR_STAGE(2), .FWD_EN(1), .BUSY_MAX(4)) u1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .ex_busy(ex_busy), .fwd_a(fa1), .fwd_b(fb1), .pc_en(pc1), .ifid_en(ifid1),
    .idex_en(idex1), .ifid_flush(iff1), .idex_flush(idf1), .exmem_flush(exf1), .hz_state(hz1),
    .busy_timeout(to1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl_unit #(.AW(5), .CNT_W(4), .BR_STAGE(2), .FWD_EN(0), .BUSY_MAX(4)) u0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .ex_busy(ex_busy), .fwd_a(fa0), .fwd_b(fb0), .pc_en(pc0), .ifid_en(ifid0),
    .idex_en(idex0), .ifid_flush(iff0), .idex_flush(idf0), .exmem_flush(exf0), .hz_state(hz0),
    .busy_timeout(to0), .stall_cnt(sc0), .flush_cnt(fc0));

  assign o1 = {fa1, fb1, pc1, ifid1, idex1, iff1, idf1, exf1};
  assign o0 = {fa0, fb0, pc0, ifid0, idex0, iff0, idf0, exf0};
  assign r1 = {to1, hz1, sc1, fc1};
  assign r0 = {to0, hz0, sc0, fc0};

  task push(input string nm, input logic [15:0] v);
    nq.push_back(nm);
    vq.push_back(v);
  endtask

  task idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, br_taken, ex_busy} = '0;
  endtask

  task reset_dut();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task test_reset();
    idle();
    rst = 1'b1;
    br_taken = 1'b1; ex_busy = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3;
    push("rst_comb_fwd1", 16'(RUN_O));
    push("rst_comb_fwd0", 16'(RUN_O));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o0} !== ev) $display("FAIL %s got %h expected %h", n, o0, ev); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    push("rst_regs", 16'd0);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    rst = 1'b0;
    idle();
  endtask

  task test_forward();
    logic [4:0] er1 [4] = '{5'd3, 5'd3, 5'd0, 5'd0};
    logic [4:0] er2 [4] = '{5'd0, 5'd3, 5'd3, 5'd9};
    logic       mw  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [9:0] ex1 [4] = '{10'b1000111000, 10'b0101111000, 10'b0010111000, 10'b0000111000};
    reset_dut();
    wb_regwrite = 1'b1; mem_rd = 5'd3; wb_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      ex_rs1 = er1[i]; ex_rs2 = er2[i]; mem_regwrite = mw[i];
      push($sformatf("fwd_fwd1_%0d", i), 16'(ex1[i]));
      push($sformatf("fwd_fwd0_%0d", i), 16'(RUN_O));
      @(negedge clk);
      n = nq.pop_front(); ev = vq.pop_front(); total++;
      if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
      n = nq.pop_front(); ev = vq.pop_front(); total++;
      if ({6'd0, o0} !== ev) $display("FAIL %s got %h expected %h", n, o0, ev); else pass_cnt++;
      @(posedge clk);
      #1;
    end
    idle();
  endtask

  task test_load_use();
    reset_dut();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use2 = 1'b1;
    push("lu_comb_fwd1", 16'(RAW_O));
    push("lu_comb_fwd0", 16'(RAW_O));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o0} !== ev) $display("FAIL %s got %h expected %h", n, o0, ev); else pass_cnt++;
    push("lu_regs", 16'({1'b0, 2'b10, 4'd1, 4'd0}));
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    ex_rd = 5'd0; id_rs2 = 5'd0;
    push("lu_x0_fwd1", 16'(RUN_O));
    push("lu_x0_fwd0", 16'(RUN_O));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o0} !== ev) $display("FAIL %s got %h expected %h", n, o0, ev); else pass_cnt++;
    @(posedge clk);
    #1 idle();
  endtask

  task test_branch();
    reset_dut();
    br_taken = 1'b1; ex_busy = 1'b1;
    push("br_comb", 16'(FLUSH_O));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    push("br_regs", 16'({1'b0, 2'b01, 4'd0, 4'd1}));
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    idle();
  endtask

  task test_watchdog();
    reset_dut();
    ex_busy = 1'b1;
    push("wd_comb", 16'(BUSY_O));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    push("wd_edge3", 16'({1'b0, 2'b11, 4'd3, 4'd0}));
    push("wd_edge4", 16'({1'b1, 2'b11, 4'd4, 4'd0}));
    push("wd_sticky", 16'({1'b1, 2'b00, 4'd4, 4'd0}));
    repeat (3) @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    @(posedge clk);
    #1 ex_busy = 1'b0;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    reset_dut();
    push("wd_rst_clear", 16'd0);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    push("wd_gap_no_timeout", 16'({1'b0, 2'b11, 4'd6, 4'd0}));
    ex_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 ex_busy = 1'b0;
    @(posedge clk);
    #1 ex_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    idle();
  endtask

  task test_fwd_en0();
    reset_dut();
    mem_regwrite = 1'b1; mem_rd = 5'd7; id_rs1 = 5'd7; id_use1 = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    push("nofwd_stall", 16'(RAW_O));
    push("fwd_no_stall", 16'(10'b1010111000));
    @(negedge clk);
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o0} !== ev) $display("FAIL %s got %h expected %h", n, o0, ev); else pass_cnt++;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({6'd0, o1} !== ev) $display("FAIL %s got %h expected %h", n, o1, ev); else pass_cnt++;
    push("nofwd_regs", 16'({1'b0, 2'b10, 4'd1, 4'd0}));
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r0} !== ev) $display("FAIL %s got %h expected %h", n, r0, ev); else pass_cnt++;
    idle();
  endtask

  task test_saturation();
    reset_dut();
    ex_busy = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2; id_use1 = 1'b1;
    push("sat_busy_raw_once", 16'({1'b0, 2'b11, 4'd1, 4'd0}));
    push("sat_20", 16'({1'b1, 2'b11, 4'd15, 4'd0}));
    push("sat_hold", 16'({1'b1, 2'b11, 4'd15, 4'd0}));
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    repeat (19) @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    @(posedge clk);
    #1;
    n = nq.pop_front(); ev = vq.pop_front(); total++;
    if ({5'd0, r1} !== ev) $display("FAIL %s got %h expected %h", n, r1, ev); else pass_cnt++;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_watchdog();
    test_fwd_en0();
    test_saturation();
    total++;
    if (nq.size() != 0) $display("FAIL scoreboard_drain got %0d expected 0", nq.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
